event_scheduler: RTL and testbench
==================================

Name: event_scheduler

Overview:
- Shared microsecond time base plus a 4-channel periodic event scheduler for the game logic.
- Typical channels: invader step, player bullet, alien bullet, UFO.
- Generates a 1 us tick from the system clock and keeps one programmable down-counter per channel.
- Delivers expired events one at a time to the game FSM over a valid/ready handshake, with round-robin arbitration and per-channel sticky overrun flags.

Parameters:
- CLK_FREQ, 36, system clock cycles per 1 us tick (36 MHz clock).
- PW, 16, period width in microseconds.
- NUM_CH, 4, number of channels; fixed at 4, so channel index is 2 bits.

Ports:
- i_clk_25MHz  input  1  system clock (36 MHz despite the name).
- i_reset_n  input  1  asynchronous, active-low reset.
- i_cfg_we  input  1  config write strobe, one cycle.
- i_cfg_ch  input  2  channel being written.
- i_cfg_period  input  PW  period in us; 0 means the channel never expires.
- i_cfg_en  input  1  channel enable.
- i_evt_ready  input  1  consumer accepts the offered event.
- i_overrun_clr  input  1  clears all overrun flags.
- o_tick  output  1  1-cycle pulse, once every CLK_FREQ cycles.
- o_evt_valid  output  1  event offered.
- o_evt_ch  output  2  channel of the offered event.
- o_overrun  output  4  sticky per-channel overrun flags.

Behaviour:
- Reset (async assert, sync release): prescaler=0, all counters/periods/enables/pending=0, o_tick=0, o_evt_valid=0, o_evt_ch=0, o_overrun=0, rr_ptr=3 (ch0 wins first).
- Prescaler:
  - Counts 0..CLK_FREQ-1 and wraps.
  - o_tick is registered, high in the cycle after the prescaler equals CLK_FREQ-1.
  - First o_tick is CLK_FREQ cycles after reset release, then every CLK_FREQ cycles.
  - Not affected by config writes.
- Config write (i_cfg_we=1):
  - period[ch]<=i_cfg_period, en[ch]<=i_cfg_en, cnt[ch]<=i_cfg_period-1 (0 if period=0).
  - pending[ch]<=0 unless ch is the channel currently offered; an offer in flight is never withdrawn.
  - o_overrun is unaffected.
  - A write and an internal tick in the same cycle on the same channel: the write wins and the tick is ignored for that channel.
- Channel count (internal tick, en[ch]=1, period[ch]!=0):
  - cnt==0: expire and reload cnt<=period-1.
  - Otherwise: cnt<=cnt-1.
  - First expiry occurs on the period[ch]-th tick after the write.
  - Disabled or period=0: counter frozen, no expiry, existing pending retained.
- Expiry:
  - pending[ch]=0: pending[ch]<=1.
  - pending[ch]=1 and not being accepted this cycle: o_overrun[ch]<=1, pending stays 1 (the event is merged).
  - Expiry in the same cycle as acceptance of that channel: pending stays 1, no overrun.
- Delivery FSM, two states:
  - IDLE: if any pending, select the first pending channel searching rr_ptr+1, rr_ptr+2, … modulo 4. Register o_evt_ch<=sel and o_evt_valid<=1, then go to OFFER. Grant is 1 cycle after pending is set.
  - OFFER: o_evt_valid and o_evt_ch held stable until i_evt_ready=1. In that cycle: pending[o_evt_ch]<=0 (subject to the expiry rule), rr_ptr<=o_evt_ch, o_evt_valid<=0, go to IDLE.
  - i_evt_ready is ignored in IDLE. Maximum throughput is one event per 2 cycles.
- Overrun clear: i_overrun_clr zeroes o_overrun. A new overrun in the same cycle wins, so that bit reads 1.
- Reset mid-operation: everything returns to reset values immediately. Pending events and the in-flight offer are discarded.
- Widths: counters are PW bits; period-1 is computed only when period!=0, so no wrap.

Test Plan:
- Reset release, no config -> o_tick first high at cycle 36 after release, then every 36 cycles; o_evt_valid stays 0.
- Write ch0 period=3 en=1, hold i_evt_ready=1 -> o_evt_valid=1 with o_evt_ch=0 one cycle after the 3rd o_tick following the write, dropping the next cycle; repeats every 3 ticks; o_overrun=0.
- Write ch0..ch3 all period=1 en=1, i_evt_ready=0 for 2 ticks, then 1 -> o_overrun=4'b1111 after the 2nd tick; accepted order 0,1,2,3, each valid 1 cycle with 1 idle cycle between; i_overrun_clr then -> o_overrun=0.
- ch1 offered with i_evt_ready=0, then config write ch1 en=0 -> o_evt_valid stays 1 with ch=1 until ready; afterwards no further ch1 events.
- ch2 period=2 and expiry coincident with acceptance of ch2 -> o_evt_valid reasserts for ch2 two cycles later; o_overrun[2]=0.
- i_reset_n low while o_evt_valid=1 -> o_evt_valid=0 and o_overrun=0 immediately (asynchronously); after release, no events until channels are reprogrammed.

Source files
------------

// File: rtl/event_scheduler.sv
// ============================================================================
// event_scheduler : 1 us time base + 4-channel periodic event scheduler
// Revision 1.0
// ============================================================================
`default_nettype none

module event_scheduler #(
   parameter int CLK_FREQ = 36,
   parameter int PW       = 16,
   parameter int NUM_CH   = 4
) (
   input  logic              i_clk_25MHz,
   input  logic              i_reset_n,
   input  logic              i_cfg_we,
   input  logic [1:0]        i_cfg_ch,
   input  logic [PW-1:0]     i_cfg_period,
   input  logic              i_cfg_en,
   input  logic              i_evt_ready,
   input  logic              i_overrun_clr,
   output logic              o_tick,
   output logic              o_evt_valid,
   output logic [1:0]        o_evt_ch,
   output logic [NUM_CH-1:0] o_overrun
);

   localparam int              PSW      = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
   localparam logic [PSW-1:0]  PSC_LAST = PSW'(CLK_FREQ - 1);
   localparam logic [0:0]      ST_IDLE  = 1'b0;
   localparam logic [0:0]      ST_OFFER = 1'b1;

   logic [PSW-1:0]    psc;
   logic              tick_int;
   logic [0:0]        state;
   logic [0:0]        state_nxt;
   logic [1:0]        rr_ptr;
   logic [1:0]        sel;
   logic [1:0]        idx;
   logic              any_pend;
   logic              load_offer;
   logic              accept;
   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] pending_nxt;
   logic [NUM_CH-1:0] overrun_set;
   logic [NUM_CH-1:0] expire;

   // Prescaler: the internal tick fires one cycle ahead of the o_tick pulse
   assign tick_int = (psc == PSC_LAST);

   always_ff @(posedge i_clk_25MHz or negedge i_reset_n) begin
      if (!i_reset_n) begin
         psc    <= '0;
         o_tick <= 1'b0;
      end else begin
         psc    <= tick_int ? '0 : psc + PSW'(1);
         o_tick <= tick_int;
      end
   end

   generate
      for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
         logic [PW-1:0] period;
         logic [PW-1:0] cnt;
         logic          en;
         logic          cfg_hit;
         logic          offered;
         logic          acc;
         logic          counting;
         logic          pend_n;
         logic          ovr_s;

         assign cfg_hit   = i_cfg_we && (i_cfg_ch == 2'(g));
         assign offered   = (state == ST_OFFER) && (o_evt_ch == 2'(g));
         assign acc       = offered && i_evt_ready;
         assign counting  = tick_int && en && (period != '0);
         assign expire[g] = counting && (cnt == '0) && !cfg_hit;

         always_ff @(posedge i_clk_25MHz or negedge i_reset_n) begin
            if (!i_reset_n) begin
               period <= '0;
               cnt    <= '0;
               en     <= 1'b0;
            end else if (cfg_hit) begin
               period <= i_cfg_period;
               en     <= i_cfg_en;
               cnt    <= (i_cfg_period == '0) ? '0 : i_cfg_period - PW'(1);
            end else if (counting) begin
               cnt    <= (cnt == '0) ? period - PW'(1) : cnt - PW'(1);
            end
         end

         // A write never withdraws an event that is already on offer
         always_comb begin
            pend_n = pending[g];
            ovr_s  = 1'b0;
            if (cfg_hit && !offered) begin
               pend_n = 1'b0;
            end else if (expire[g]) begin
               pend_n = 1'b1;
               ovr_s  = pending[g] && !acc;
            end else if (acc) begin
               pend_n = 1'b0;
            end
         end

         assign pending_nxt[g] = pend_n;
         assign overrun_set[g] = ovr_s;
      end
   endgenerate

   // Round-robin pick: the lowest distance after rr_ptr wins
   always_comb begin
      sel      = rr_ptr;
      idx      = rr_ptr;
      any_pend = |pending;
      for (int i = NUM_CH; i >= 1; i--) begin
         idx = rr_ptr + 2'(i);
         if (pending[idx]) begin
            sel = idx;
         end
      end
   end

   always_ff @(posedge i_clk_25MHz or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (any_pend)    state_nxt = ST_OFFER;
         ST_OFFER: if (i_evt_ready) state_nxt = ST_IDLE;
         default:                   state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      o_evt_valid = (state == ST_OFFER);
      load_offer  = (state == ST_IDLE) && any_pend;
      accept      = (state == ST_OFFER) && i_evt_ready;
   end

   always_ff @(posedge i_clk_25MHz or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_evt_ch  <= 2'd0;
         rr_ptr    <= 2'd3;
         pending   <= '0;
         o_overrun <= '0;
      end else begin
         if (load_offer) begin
            o_evt_ch <= sel;
         end
         if (accept) begin
            rr_ptr <= o_evt_ch;
         end
         pending   <= pending_nxt;
         o_overrun <= (o_overrun & ~{NUM_CH{i_overrun_clr}}) | overrun_set;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_event_scheduler.sv
// ============================================================================
// tb_event_scheduler : randomized bench for event_scheduler vs. a tick-level model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_event_scheduler;

   localparam int CLK_FREQ = 36;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cfg_we;
   logic [1:0]  cfg_ch;
   logic [15:0] cfg_period;
   logic        cfg_en;
   logic        evt_ready;
   logic        overrun_clr;
   logic        tick;
   logic        evt_valid;
   logic [1:0]  evt_ch;
   logic [3:0]  overrun;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: ticks remaining until each channel's next expiry
   int   cyc;
   int   m_per  [4];
   int   m_left [4];
   bit   m_en   [4];
   bit   m_pend [4];
   bit   m_ov   [4];
   bit   m_off;
   int   m_och;
   int   m_last;

   always #5 clk = ~clk;

   event_scheduler #(.CLK_FREQ(CLK_FREQ), .PW(16), .NUM_CH(4)) dut (
      .i_clk_25MHz   (clk),
      .i_reset_n     (reset_n),
      .i_cfg_we      (cfg_we),
      .i_cfg_ch      (cfg_ch),
      .i_cfg_period  (cfg_period),
      .i_cfg_en      (cfg_en),
      .i_evt_ready   (evt_ready),
      .i_overrun_clr (overrun_clr),
      .o_tick        (tick),
      .o_evt_valid   (evt_valid),
      .o_evt_ch      (evt_ch),
      .o_overrun     (overrun)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", tag, obs, exp, cyc, $time);
      end
   endtask

   function automatic logic [3:0] model_ov();
      logic [3:0] v;
      for (int c = 0; c < 4; c++) v[c] = m_ov[c];
      return v;
   endfunction

   task automatic model_reset();
      cyc    = 0;
      m_off  = 0;
      m_och  = 0;
      m_last = 3;
      for (int c = 0; c < 4; c++) begin
         m_per[c] = 0; m_left[c] = 0; m_en[c] = 0; m_pend[c] = 0; m_ov[c] = 0;
      end
   endtask

   task automatic model_step();
      bit tk;
      bit np  [4];
      bit nov [4];
      bit hit, exp_now, acc, offd, found;
      int c2;
      tk = ((cyc % CLK_FREQ) == CLK_FREQ - 1);
      for (int c = 0; c < 4; c++) begin
         hit     = cfg_we && (int'(cfg_ch) == c);
         offd    = m_off && (m_och == c);
         acc     = offd && evt_ready;
         exp_now = 0;
         nov[c]  = 0;
         if (hit) begin
            m_per[c]  = int'(cfg_period);
            m_en[c]   = cfg_en;
            m_left[c] = int'(cfg_period);
         end else if (tk && m_en[c] && m_per[c] != 0) begin
            m_left[c]--;
            if (m_left[c] == 0) begin
               exp_now   = 1;
               m_left[c] = m_per[c];
            end
         end
         if (hit && !offd)   np[c] = 0;
         else if (exp_now) begin
            np[c]  = 1;
            nov[c] = m_pend[c] && !acc;
         end
         else if (acc)       np[c] = 0;
         else                np[c] = m_pend[c];
      end
      if (m_off) begin
         if (evt_ready) begin
            m_off  = 0;
            m_last = m_och;
         end
      end else begin
         found = 0;
         for (int k = 1; k <= 4; k++) begin
            c2 = (m_last + k) % 4;
            if (!found && m_pend[c2]) begin
               found = 1;
               m_och = c2;
               m_off = 1;
            end
         end
      end
      for (int c = 0; c < 4; c++) begin
         m_pend[c] = np[c];
         m_ov[c]   = (m_ov[c] && !overrun_clr) || nov[c];
      end
      cyc++;
   endtask

   task automatic compare_outputs();
      check("tick",    32'(tick),      32'(cyc > 0 && (cyc % CLK_FREQ) == 0));
      check("valid",   32'(evt_valid), 32'(m_off));
      check("evt_ch",  32'(evt_ch),    32'(m_och));
      check("overrun", 32'(overrun),   32'(model_ov()));
   endtask

   task automatic run_cycle(input bit we, input int ch, input int per, input bit en,
                            input bit rdy, input bit clr);
      cfg_we      = we;
      cfg_ch      = 2'(ch);
      cfg_period  = 16'(per);
      cfg_en      = en;
      evt_ready   = rdy;
      overrun_clr = clr;
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_outputs();
   endtask

   initial begin
      int guard;
      reset_n = 1'b0;
      cfg_we = 0; cfg_ch = 0; cfg_period = 0; cfg_en = 0; evt_ready = 0; overrun_clr = 0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      compare_outputs();
      reset_n = 1'b1;
      compare_outputs();

      // Idle time base only
      repeat (80) run_cycle(0, 0, 0, 0, 1'($urandom % 2), 0);

      // Single channel, always-ready consumer
      run_cycle(1, 0, 3, 1, 1, 0);
      repeat (400) run_cycle(0, 0, 0, 0, 1, 0);

      // All channels period 1, consumer stalled across two ticks
      for (int c = 0; c < 4; c++) run_cycle(1, c, 1, 1, 0, 0);
      repeat (80) run_cycle(0, 0, 0, 0, 0, 0);
      check("overrun_all", 32'(overrun), 32'hF);
      repeat (12) run_cycle(0, 0, 0, 0, 1, 0);
      run_cycle(0, 0, 0, 0, 1, 1);
      for (int c = 0; c < 4; c++) run_cycle(1, c, 0, 0, 1, 0);
      repeat (10) run_cycle(0, 0, 0, 0, 1, 0);

      // Disable a channel while its event is on offer
      run_cycle(1, 1, 1, 1, 0, 0);
      guard = 0;
      while (!(m_off && m_och == 1) && guard < 100) begin
         run_cycle(0, 0, 0, 0, 0, 0);
         guard++;
      end
      check("ch1_offer_seen", 32'(guard < 100), 32'd1);
      run_cycle(1, 1, 1, 0, 0, 0);
      repeat (5) run_cycle(0, 0, 0, 0, 0, 0);
      repeat (200) run_cycle(0, 0, 0, 0, 1, 0);

      // Expiry coinciding with acceptance of the same channel
      run_cycle(1, 2, 2, 1, 0, 0);
      guard = 0;
      while (!(m_off && m_och == 2 && (cyc % CLK_FREQ) == CLK_FREQ - 1 && m_left[2] == 1)
             && guard < 400) begin
         run_cycle(0, 0, 0, 0, 0, 0);
         guard++;
      end
      check("coincide_reached", 32'(guard < 400), 32'd1);
      run_cycle(0, 0, 0, 0, 1, 0);
      repeat (10) run_cycle(0, 0, 0, 0, 1, 0);
      check("ch2_no_overrun", 32'(overrun[2]), 32'd0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         run_cycle(($urandom % 40) == 0, int'($urandom % 4), int'($urandom % 5),
                   ($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 25) == 0);
      end

      // Asynchronous reset while an event is on offer
      run_cycle(1, 0, 1, 1, 0, 0);
      guard = 0;
      while (!m_off && guard < 300) begin
         run_cycle(0, 0, 0, 0, 0, 0);
         guard++;
      end
      check("offer_before_reset", 32'(m_off), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check("rst_valid",   32'(evt_valid), 32'd0);
      check("rst_overrun", 32'(overrun),   32'd0);
      check("rst_tick",    32'(tick),      32'd0);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      compare_outputs();
      repeat (120) run_cycle(0, 0, 0, 0, 1'($urandom % 2), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
